control_decode_stage: RTL and testbench

Pipelined successor to the single-cycle decode control unit. It accepts one RV32I/RV32M instruction per cycle over a valid/ready handshake, decodes it, and holds the control word in an output register. Multiply/divide instructions are held for a parametrised number of cycles before the control word is released. It sits between fetch and execute and supports stall, flush and illegal-opcode flagging.

---
 rtl/control_decode_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_control_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_decode_stage.sv
// Decode stage between fetch and execute: RV32I/RV32M decode into a registered
// control word, with stall hold, flush, and multi-cycle holding of mul/div ops.
//
// state   | meaning
// DECODE  | accepting instructions; output register holds last decoded word
// MD_BUSY | mul/div accepted; counting execute occupancy before releasing Valid_o
module control_decode_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int ENABLE_M    = 1,
  parameter int MUL_LATENCY = 3,
  parameter int DIV_LATENCY = 34
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] Instr_i,
  input  logic                  Valid_i,
  output logic                  Ready_o,
  input  logic                  Stall_i,
  input  logic                  Flush_i,
  output logic                  Valid_o,
  output logic                  RegWrite_o,
  output logic [3:0]            ALUCtrl_o,
  output logic                  ALUSrc_o,
  output logic [2:0]            ImmSrc_o,
  output logic                  MemWrite_o,
  output logic [1:0]            ResultSrc_o,
  output logic [1:0]            MemType_o,
  output logic                  MemSign_o,
  output logic                  JumpSrc_o,
  output logic [2:0]            Branch_o,
  output logic                  BranchInstr_o,
  output logic                  MulDiv_o,
  output logic [2:0]            MulDivOp_o,
  output logic                  Illegal_o
);

  localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_LATENCY);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic {DECODE, MD_BUSY} state_t;

  typedef struct packed {
    logic       reg_write;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [2:0] imm_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] mem_type;
    logic       mem_sign;
    logic       jump_src;
    logic [2:0] branch;
    logic       branch_instr;
    logic       mul_div;
    logic [2:0] mul_div_op;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{branch: 3'b010, default: '0};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  ctrl_t            ctrl_q, ctrl_d;

  ctrl_t            dec;
  logic [CNT_W-1:0] md_lat;
  logic             hold, accept;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  // Register and immediate fields are consumed downstream, not here.
  logic unused_instr;
  assign unused_instr = ^Instr_i;

  assign opcode = Instr_i[6:0];
  assign funct3 = Instr_i[14:12];
  assign funct7 = Instr_i[31:25];

  // alt selects sub (funct3=000) or sra (funct3=101); ignored elsewhere.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? 4'b0001 : 4'b0000;
      3'b001:  op = 4'b1000;
      3'b010:  op = 4'b0101;
      3'b011:  op = 4'b0110;
      3'b100:  op = 4'b0100;
      3'b101:  op = alt ? 4'b1001 : 4'b0111;
      3'b110:  op = 4'b0011;
      default: op = 4'b0010;
    endcase
    return op;
  endfunction

  function automatic logic [1:0] mem_size(input logic [2:0] f3);
    logic [1:0] t;
    case (f3[1:0])
      2'b00:   t = 2'b01;
      2'b01:   t = 2'b10;
      default: t = 2'b00;
    endcase
    return t;
  endfunction

  always_comb begin
    dec    = CTRL_RST;
    md_lat = funct3[2] ? DIV_L : MUL_L;
    case (opcode)
      7'd3: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        dec.mem_type   = mem_size(funct3);
        dec.mem_sign   = funct3[2];
      end
      7'd19: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = alu_op(funct3, funct7[5] && (funct3 == 3'b101));
      end
      7'd23, 7'd55: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'b011;
      end
      7'd35: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'b001;
        dec.mem_type  = mem_size(funct3);
      end
      7'd51: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec.reg_write = 1'b1;
          dec.alu_ctrl  = alu_op(funct3, funct7[5]);
        end else if (funct7 == 7'b0000001 && ENABLE_M != 0) begin
          dec.reg_write  = 1'b1;
          dec.mul_div    = 1'b1;
          dec.mul_div_op = funct3;
          dec.result_src = 2'b11;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      7'd99: begin
        dec.branch_instr = 1'b1;
        dec.branch       = funct3;
        dec.imm_src      = 3'b010;
        dec.alu_ctrl     = 4'b0001;
      end
      7'd103: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b10;
        dec.jump_src   = 1'b1;
      end
      7'd111: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm_src    = 3'b100;
        dec.result_src = 2'b10;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign hold    = (state_q == DECODE) && valid_q && Stall_i;
  assign Ready_o = (state_q == DECODE) && !(valid_q && Stall_i) && !Flush_i;
  assign accept  = Valid_i && Ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    if (Flush_i) begin
      valid_d = 1'b0;
      state_d = DECODE;
      cnt_d   = '0;
    end else if (state_q == MD_BUSY) begin
      cnt_d = cnt_q - ONE;
      if (cnt_q == ONE) begin
        valid_d = 1'b1;
        state_d = DECODE;
      end
    end else if (hold) begin
      valid_d = valid_q;
    end else if (accept) begin
      ctrl_d = dec;
      if (dec.mul_div && md_lat > ONE) begin
        valid_d = 1'b0;
        cnt_d   = md_lat - ONE;
        state_d = MD_BUSY;
      end else begin
        valid_d = 1'b1;
      end
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DECODE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign Valid_o       = valid_q;
  assign RegWrite_o    = ctrl_q.reg_write;
  assign ALUCtrl_o     = ctrl_q.alu_ctrl;
  assign ALUSrc_o      = ctrl_q.alu_src;
  assign ImmSrc_o      = ctrl_q.imm_src;
  assign MemWrite_o    = ctrl_q.mem_write;
  assign ResultSrc_o   = ctrl_q.result_src;
  assign MemType_o     = ctrl_q.mem_type;
  assign MemSign_o     = ctrl_q.mem_sign;
  assign JumpSrc_o     = ctrl_q.jump_src;
  assign Branch_o      = ctrl_q.branch;
  assign BranchInstr_o = ctrl_q.branch_instr;
  assign MulDiv_o      = ctrl_q.mul_div;
  assign MulDivOp_o    = ctrl_q.mul_div_op;
  assign Illegal_o     = ctrl_q.illegal;

endmodule

// File: tb/tb_control_decode_stage.sv
// Scoreboarded bench for control_decode_stage: directed scenarios followed by
// randomized instruction/stall/flush/reset traffic against a behavioural model.
module tb_control_decode_stage;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 34;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] instr;
  logic        valid_i, stall, flush, rst;
  logic        Ready_o, Valid_o, RegWrite_o, ALUSrc_o, MemWrite_o, MemSign_o;
  logic        JumpSrc_o, BranchInstr_o, MulDiv_o, Illegal_o;
  logic [3:0]  ALUCtrl_o;
  logic [2:0]  ImmSrc_o, Branch_o, MulDivOp_o;
  logic [1:0]  ResultSrc_o, MemType_o;

  logic [31:0] n_instr;
  logic        n_valid, n_rst;
  logic        n_ready, n_vo, n_rw, n_as, n_mw, n_ms, n_js, n_bi, n_md, n_il;
  logic [3:0]  n_alu;
  logic [2:0]  n_imm, n_br, n_mdop;
  logic [1:0]  n_rs, n_mt;

  control_decode_stage #(.DATA_WIDTH(32), .ENABLE_M(1), .MUL_LATENCY(MUL_LAT),
                         .DIV_LATENCY(DIV_LAT)) u_dut (
    .clk_i(clk), .rst_i(rst), .Instr_i(instr), .Valid_i(valid_i), .Ready_o(Ready_o),
    .Stall_i(stall), .Flush_i(flush), .Valid_o(Valid_o), .RegWrite_o(RegWrite_o),
    .ALUCtrl_o(ALUCtrl_o), .ALUSrc_o(ALUSrc_o), .ImmSrc_o(ImmSrc_o),
    .MemWrite_o(MemWrite_o), .ResultSrc_o(ResultSrc_o), .MemType_o(MemType_o),
    .MemSign_o(MemSign_o), .JumpSrc_o(JumpSrc_o), .Branch_o(Branch_o),
    .BranchInstr_o(BranchInstr_o), .MulDiv_o(MulDiv_o), .MulDivOp_o(MulDivOp_o),
    .Illegal_o(Illegal_o));

  control_decode_stage #(.DATA_WIDTH(32), .ENABLE_M(0), .MUL_LATENCY(MUL_LAT),
                         .DIV_LATENCY(DIV_LAT)) u_nom (
    .clk_i(clk), .rst_i(n_rst), .Instr_i(n_instr), .Valid_i(n_valid), .Ready_o(n_ready),
    .Stall_i(1'b0), .Flush_i(1'b0), .Valid_o(n_vo), .RegWrite_o(n_rw),
    .ALUCtrl_o(n_alu), .ALUSrc_o(n_as), .ImmSrc_o(n_imm), .MemWrite_o(n_mw),
    .ResultSrc_o(n_rs), .MemType_o(n_mt), .MemSign_o(n_ms), .JumpSrc_o(n_js),
    .Branch_o(n_br), .BranchInstr_o(n_bi), .MulDiv_o(n_md), .MulDivOp_o(n_mdop),
    .Illegal_o(n_il));

  typedef struct packed {
    logic       reg_write;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic [2:0] imm_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic [1:0] mem_type;
    logic       mem_sign;
    logic       jump_src;
    logic [2:0] branch;
    logic       branch_instr;
    logic       mul_div;
    logic [2:0] mul_div_op;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    ctrl_t c;
    int    due;
  } exp_t;

  localparam ctrl_t RST_C = '{branch: 3'b010, default: '0};
  // funct3 -> add sll slt sltu xor srl or and
  localparam logic [3:0] ALU_TAB [8] = '{4'd0, 4'd8, 4'd5, 4'd6, 4'd4, 4'd7, 4'd3, 4'd2};

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_LBU  = 32'h00014083;
  localparam logic [31:0] I_DIV  = 32'h023140B3;
  localparam logic [31:0] I_MUL  = 32'h023100B3;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_SRAI = 32'h40115093;
  localparam logic [31:0] I_ADDI = 32'h40010093;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  int   total = 0;
  int   passed = 0;
  int   cyc = 0;
  exp_t q[$];
  bit   m_valid = 0;
  bit   m_ready = 0;
  int   m_busy = 0;
  bit   started = 0;
  bit   nom_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c = '{RegWrite_o, ALUCtrl_o, ALUSrc_o, ImmSrc_o, MemWrite_o, ResultSrc_o, MemType_o,
          MemSign_o, JumpSrc_o, Branch_o, BranchInstr_o, MulDiv_o, MulDivOp_o, Illegal_o};
    return c;
  endfunction

  function automatic ctrl_t exp_decode(input logic [31:0] ins, input bit en_m);
    ctrl_t c;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [1:0] sz;
    c  = RST_C;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    sz = (f3[1:0] == 2'd0) ? 2'd1 : (f3[1:0] == 2'd1) ? 2'd2 : 2'd0;
    if (op == 7'd3) begin
      c.reg_write = 1; c.alu_src = 1; c.result_src = 2'd1; c.mem_type = sz; c.mem_sign = f3[2];
    end else if (op == 7'd19) begin
      c.reg_write = 1; c.alu_src = 1; c.alu_ctrl = ALU_TAB[f3];
      if (f3 == 3'd5 && f7[5]) c.alu_ctrl = 4'd9;
    end else if (op == 7'd23 || op == 7'd55) begin
      c.reg_write = 1; c.alu_src = 1; c.imm_src = 3'd3;
    end else if (op == 7'd35) begin
      c.mem_write = 1; c.alu_src = 1; c.imm_src = 3'd1; c.mem_type = sz;
    end else if (op == 7'd51 && (f7 == 7'h00 || f7 == 7'h20)) begin
      c.reg_write = 1; c.alu_ctrl = ALU_TAB[f3];
      if (f7[5] && f3 == 3'd0) c.alu_ctrl = 4'd1;
      if (f7[5] && f3 == 3'd5) c.alu_ctrl = 4'd9;
    end else if (op == 7'd51 && f7 == 7'h01 && en_m) begin
      c.reg_write = 1; c.mul_div = 1; c.mul_div_op = f3; c.result_src = 2'd3;
    end else if (op == 7'd99) begin
      c.branch_instr = 1; c.branch = f3; c.imm_src = 3'd2; c.alu_ctrl = 4'd1;
    end else if (op == 7'd103) begin
      c.reg_write = 1; c.alu_src = 1; c.result_src = 2'd2; c.jump_src = 1;
    end else if (op == 7'd111) begin
      c.reg_write = 1; c.alu_src = 1; c.imm_src = 3'd4; c.result_src = 2'd2;
    end else begin
      c.illegal = 1;
    end
    return c;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          sel;
    logic [6:0]  ops [9];
    ops = '{7'd3, 7'd19, 7'd23, 7'd35, 7'd51, 7'd55, 7'd99, 7'd103, 7'd111};
    r   = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 9) r[6:0] = ops[sel];
    else if (sel == 9) begin r[6:0] = 7'd51; r[31:25] = 7'h01; end
    else if (sel == 10) begin r[6:0] = 7'd51; r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
    return r;
  endfunction

  // Reference timing: each accepted word appears after its execute occupancy.
  task automatic model_edge();
    exp_t e;
    int   lat;
    cyc++;
    if (rst || flush) begin
      m_valid = 0; m_busy = 0; q.delete();
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_valid = 1;
    end else if (m_valid && stall) begin
      m_valid = 1;
    end else if (valid_i && m_ready) begin
      e.c   = exp_decode(instr, 1'b1);
      lat   = e.c.mul_div ? (instr[14] ? DIV_LAT : MUL_LAT) : 1;
      e.due = cyc + lat - 1;
      q.push_back(e);
      m_busy  = lat - 1;
      m_valid = (lat == 1);
    end else begin
      m_valid = 0;
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic v, input logic s,
                       input logic f, input logic r);
    instr = ins; valid_i = v; stall = s; flush = f; rst = r;
    m_ready = (m_busy == 0) && !(m_valid && s) && !f;
    @(posedge clk);
    model_edge();
    #2;
  endtask

  // Monitor: compares handshake each cycle and pops one expectation per new word.
  bit    awaiting = 1;
  bit    p_valid = 0, p_stall = 0, p_flush = 0, p_rst = 1;
  ctrl_t last_c = RST_C;
  always @(negedge clk) begin
    exp_t e;
    if (p_rst || p_flush || (p_valid && !p_stall)) awaiting = 1;
    if (started) begin
      chk("ready", Ready_o, m_ready);
      chk("valid", Valid_o, m_valid);
      if (Valid_o === 1'b1) begin
        if (awaiting) begin
          if (q.size() == 0) begin
            chk("unexpected_word", 64'(dut_ctrl()), 64'hDEAD);
          end else begin
            e = q.pop_front();
            chk("ctrl_word", 64'(dut_ctrl()), 64'(e.c));
            chk("latency", cyc, e.due);
            last_c = e.c;
          end
          awaiting = 0;
        end else begin
          chk("hold_word", 64'(dut_ctrl()), 64'(last_c));
        end
      end
    end
    p_valid = Valid_o; p_stall = stall; p_flush = flush; p_rst = rst;
  end

  // ENABLE_M=0 instance: M opcodes and unknown opcodes both flag illegal.
  initial begin
    n_rst = 1; n_valid = 0; n_instr = '0;
    repeat (2) @(posedge clk);
    #2 n_rst = 0; n_valid = 1; n_instr = I_MUL;
    @(posedge clk); #2;
    n_instr = I_BAD;
    chk("nom_mul_valid", n_vo, 1); chk("nom_mul_ill", n_il, 1);
    chk("nom_mul_rw", n_rw, 0); chk("nom_mul_mw", n_mw, 0); chk("nom_mul_md", n_md, 0);
    chk("nom_ready", n_ready, 1);
    @(posedge clk); #2;
    n_valid = 0;
    chk("nom_bad_valid", n_vo, 1); chk("nom_bad_ill", n_il, 1);
    chk("nom_bad_rw", n_rw, 0); chk("nom_bad_mw", n_mw, 0); chk("nom_bad_br", n_br, 3'b010);
    nom_done = 1;
  end

  initial begin
    instr = '0; valid_i = 0; stall = 0; flush = 0; rst = 1;
    drive(32'h0, 0, 0, 0, 1);
    drive(32'h0, 0, 0, 0, 1);
    started = 1;
    chk("rst_word", 64'(dut_ctrl()), 64'(RST_C));
    chk("rst_valid", Valid_o, 0);
    chk("rst_ready", Ready_o, 1);

    drive(I_ADD, 1, 0, 0, 0);
    chk("add_alu", ALUCtrl_o, 4'd0); chk("add_rw", RegWrite_o, 1);
    chk("add_rs", ResultSrc_o, 2'd0); chk("add_br", Branch_o, 3'b010);

    drive(I_LBU, 1, 0, 0, 0);
    repeat (3) begin
      drive(I_ADD, 1, 1, 0, 0);
      chk("lbu_mt", MemType_o, 2'd1); chk("lbu_ms", MemSign_o, 1); chk("lbu_rs", ResultSrc_o, 2'd1);
      chk("lbu_stall_ready", Ready_o, 0);
    end
    drive(I_ADD, 1, 0, 0, 0);
    chk("after_stall_alu", ALUCtrl_o, 4'd0);

    drive(I_DIV, 1, 0, 0, 0);
    repeat (33) drive(32'h0, 0, 0, 0, 0);
    chk("div_valid", Valid_o, 1); chk("div_op", MulDivOp_o, 3'd4);
    chk("div_rs", ResultSrc_o, 2'd3); chk("div_md", MulDiv_o, 1);
    drive(32'h0, 0, 0, 0, 0);

    drive(I_MUL, 1, 0, 0, 0);
    drive(32'h0, 0, 0, 1, 0);
    chk("flush_valid", Valid_o, 0);
    drive(I_BEQ, 1, 0, 0, 0);
    chk("beq_br", Branch_o, 3'd0); chk("beq_bi", BranchInstr_o, 1); chk("beq_rw", RegWrite_o, 0);

    drive(I_DIV, 1, 0, 0, 0);
    repeat (23) drive(32'h0, 0, 0, 0, 0);
    drive(32'h0, 0, 0, 0, 1);
    chk("rst2_valid", Valid_o, 0); chk("rst2_br", Branch_o, 3'b010); chk("rst2_ready", Ready_o, 1);
    drive(I_SRAI, 1, 0, 0, 0);
    chk("srai_alu", ALUCtrl_o, 4'd9);
    drive(I_ADDI, 1, 0, 0, 0);
    chk("addi_alu", ALUCtrl_o, 4'd0);

    repeat (1500)
      drive(rand_instr(), 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 99) == 0));
    repeat (40) drive(32'h0, 0, 0, 0, 0);
    chk("queue_drained", q.size(), 0);
    chk("nom_completed", nom_done, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
